// File: rtl/ysyx_22041461_mem_arbiter.sv
// Two-master (IF read-only, LS read/write) to one-slave memory arbiter.
// One outstanding transaction; alternating priority on contention; WAIT timeout yields a bus error.
module ysyx_22041461_mem_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,

    input  logic                if_valid,
    output logic                if_ready,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_rsp_valid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,

    input  logic                ls_valid,
    output logic                ls_ready,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic                ls_wen,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_wmask,
    output logic                ls_rsp_valid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_err,

    output logic                m_req_valid,
    input  logic                m_req_ready,
    output logic [ADDR_W-1:0]   m_addr,
    output logic                m_wen,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wmask,
    input  logic                m_rsp_valid,
    input  logic [DATA_W-1:0]   m_rdata
);

    localparam int          STRB_W   = DATA_W / 8;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_grant_q, last_grant_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wen_q, wen_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
    logic                if_err_q, if_err_d;
    logic                ls_err_q, ls_err_d;

    logic                grant_if;
    logic                grant_ls;
    logic                rsp_fire;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_IF;
            cnt_q        <= '0;
            addr_q       <= '0;
            wen_q        <= 1'b0;
            wdata_q      <= '0;
            wmask_q      <= '0;
            if_rdata_q   <= '0;
            ls_rdata_q   <= '0;
            if_err_q     <= 1'b0;
            ls_err_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wen_q        <= wen_d;
            wdata_q      <= wdata_d;
            wmask_q      <= wmask_d;
            if_rdata_q   <= if_rdata_d;
            ls_rdata_q   <= ls_rdata_d;
            if_err_q     <= if_err_d;
            ls_err_q     <= ls_err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wen_d        = wen_q;
        wdata_d      = wdata_q;
        wmask_d      = wmask_q;
        if_rdata_d   = if_rdata_q;
        ls_rdata_d   = ls_rdata_q;
        if_err_d     = if_err_q;
        ls_err_d     = ls_err_q;
        grant_if     = 1'b0;
        grant_ls     = 1'b0;
        rsp_fire     = 1'b0;
        rsp_data     = '0;
        rsp_err      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // ready is combinational, so it must also be held low while reset is asserted
                if (rst_n) begin
                    grant_ls = ls_valid && (!if_valid || (last_grant_q == OWN_IF));
                    grant_if = if_valid && !grant_ls;
                end
                if (grant_ls) begin
                    addr_d       = ls_addr;
                    wen_d        = ls_wen;
                    wdata_d      = ls_wdata;
                    wmask_d      = ls_wmask;
                    owner_d      = OWN_LS;
                    last_grant_d = OWN_LS;
                    state_d      = ST_REQ;
                end else if (grant_if) begin
                    addr_d       = if_addr;
                    wen_d        = 1'b0;
                    wdata_d      = '0;
                    wmask_d      = '0;
                    owner_d      = OWN_IF;
                    last_grant_d = OWN_IF;
                    state_d      = ST_REQ;
                end
            end

            ST_REQ: begin
                if (m_req_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                // a response in the final counted cycle takes precedence over the timeout
                if (m_rsp_valid) begin
                    rsp_fire = 1'b1;
                    rsp_data = wen_q ? '0 : m_rdata;
                    rsp_err  = 1'b0;
                end else if (cnt_q == TMO_LAST) begin
                    rsp_fire = 1'b1;
                    rsp_data = '0;
                    rsp_err  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                if (rsp_fire) begin
                    state_d = ST_RESP;
                    if (owner_q == OWN_LS) begin
                        ls_rdata_d = rsp_data;
                        ls_err_d   = rsp_err;
                    end else begin
                        if_rdata_d = rsp_data;
                        if_err_d   = rsp_err;
                    end
                end
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign if_ready     = grant_if;
    assign ls_ready     = grant_ls;
    assign m_req_valid  = (state_q == ST_REQ);
    assign m_addr       = addr_q;
    assign m_wen        = wen_q;
    assign m_wdata      = wdata_q;
    assign m_wmask      = wmask_q;
    assign if_rsp_valid = (state_q == ST_RESP) && (owner_q == OWN_IF);
    assign ls_rsp_valid = (state_q == ST_RESP) && (owner_q == OWN_LS);
    assign if_rdata     = if_rdata_q;
    assign ls_rdata     = ls_rdata_q;
    assign if_err       = if_err_q;
    assign ls_err       = ls_err_q;

endmodule

// File: tb/tb_ysyx_22041461_mem_arbiter.sv
// Scoreboard bench for the memory arbiter: directed requests push expected responses,
// a monitor pops and compares on every rsp_valid pulse; a bench slave models the downstream port.
module tb_ysyx_22041461_mem_arbiter;

    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int TMO = 4;

    logic          clk;
    logic          rst_n;
    logic          if_valid;
    logic          if_ready;
    logic [AW-1:0] if_addr;
    logic          if_rsp_valid;
    logic [DW-1:0] if_rdata;
    logic          if_err;
    logic          ls_valid;
    logic          ls_ready;
    logic [AW-1:0] ls_addr;
    logic          ls_wen;
    logic [DW-1:0] ls_wdata;
    logic [7:0]    ls_wmask;
    logic          ls_rsp_valid;
    logic [DW-1:0] ls_rdata;
    logic          ls_err;
    logic          m_req_valid;
    logic          m_req_ready;
    logic [AW-1:0] m_addr;
    logic          m_wen;
    logic [DW-1:0] m_wdata;
    logic [7:0]    m_wmask;
    logic          m_rsp_valid;
    logic [DW-1:0] m_rdata;

    ysyx_22041461_mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_valid     (if_valid),
        .if_ready     (if_ready),
        .if_addr      (if_addr),
        .if_rsp_valid (if_rsp_valid),
        .if_rdata     (if_rdata),
        .if_err       (if_err),
        .ls_valid     (ls_valid),
        .ls_ready     (ls_ready),
        .ls_addr      (ls_addr),
        .ls_wen       (ls_wen),
        .ls_wdata     (ls_wdata),
        .ls_wmask     (ls_wmask),
        .ls_rsp_valid (ls_rsp_valid),
        .ls_rdata     (ls_rdata),
        .ls_err       (ls_err),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_addr       (m_addr),
        .m_wen        (m_wen),
        .m_wdata      (m_wdata),
        .m_wmask      (m_wmask),
        .m_rsp_valid  (m_rsp_valid),
        .m_rdata      (m_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ls;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   n_if_rsp  = 0;
    int   n_ls_rsp  = 0;
    int   slv_delay = 0;
    logic slv_busy;

    function automatic logic [63:0] slave_data(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0000) return 64'h0000_0013_0010_0073;
        return {~a[31:0], a[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic push_exp(input logic is_ls, input logic [63:0] a, input logic wen, input int dly);
        exp_t e;
        e.ls    = is_ls;
        e.err   = (dly >= TMO);
        e.rdata = (e.err || wen) ? 64'h0 : slave_data(a);
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(input logic is_ls, input logic push);
        logic got;
        got = 1'b0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            if (is_ls ? ls_ready : if_ready) begin
                got = 1'b1;
                if (push) push_exp(is_ls, is_ls ? ls_addr : if_addr, is_ls ? ls_wen : 1'b0, slv_delay);
            end
            @(posedge clk);
            #1;
        end
        chk(is_ls ? "ls_grant" : "if_grant", 64'(got), 64'd1);
        if (is_ls) ls_valid = 1'b0;
        else       if_valid = 1'b0;
    endtask

    task automatic drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || slv_busy) && c < 100) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain", 64'(exp_q.size() != 0 || slv_busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        if_valid = 1'b0;
        ls_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Downstream slave: answers slv_delay cycles after the first WAIT cycle; writes return junk data.
    initial begin : slave
        logic [63:0] a;
        logic        w;
        int          d;
        m_rsp_valid = 1'b0;
        m_rdata     = '0;
        slv_busy    = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && m_req_valid && m_req_ready) begin
                slv_busy = 1'b1;
                a        = m_addr;
                w        = m_wen;
                d        = slv_delay;
                @(posedge clk);
                #1;
                for (int i = 0; i < d; i++) begin
                    @(posedge clk);
                    #1;
                end
                m_rsp_valid = 1'b1;
                m_rdata     = w ? 64'hBAD0_BAD0_BAD0_BAD0 : slave_data(a);
                @(posedge clk);
                #1;
                m_rsp_valid = 1'b0;
                m_rdata     = 64'h5555_AAAA_5555_AAAA;
                slv_busy    = 1'b0;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && (if_rsp_valid || ls_rsp_valid)) begin
                if (if_rsp_valid) n_if_rsp++;
                if (ls_rsp_valid) n_ls_rsp++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 64'({ls_rsp_valid, if_rsp_valid}), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_owner", 64'({ls_rsp_valid, if_rsp_valid}), e.ls ? 64'd2 : 64'd1);
                    chk("rsp_rdata", e.ls ? ls_rdata : if_rdata, e.rdata);
                    chk("rsp_err", 64'(e.ls ? ls_err : if_err), 64'(e.err));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin : stimulus
        int          grants;
        int          last_c;
        int          ri;
        int          rl;
        logic        exp_ls;
        logic        g_ls;
        logic        g_if;

        rst_n       = 1'b0;
        m_req_ready = 1'b1;
        if_valid    = 1'b1;
        if_addr     = 64'h8000_0000;
        ls_valid    = 1'b1;
        ls_addr     = 64'h8000_1000;
        ls_wen      = 1'b0;
        ls_wdata    = '0;
        ls_wmask    = '0;

        // Reset state, with both masters requesting.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'({if_ready, ls_ready}), 64'd0);
        chk("rst_rsp_valid", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
        chk("rst_err", 64'({if_err, ls_err}), 64'd0);
        chk("rst_if_rdata", if_rdata, 64'd0);
        chk("rst_ls_rdata", ls_rdata, 64'd0);
        chk("rst_m_req_valid", 64'(m_req_valid), 64'd0);
        chk("rst_m_addr", m_addr, 64'd0);
        chk("rst_m_wr", 64'({m_wen, m_wmask}), 64'd0);
        chk("rst_m_wdata", m_wdata, 64'd0);
        if_valid = 1'b0;
        ls_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: IF alone; LS write fields parked non-zero must not leak into an IF request.
        ls_wen    = 1'b1;
        ls_wmask  = 8'hFF;
        ls_wdata  = 64'h1111_2222_3333_4444;
        slv_delay = 0;
        if_addr   = 64'h8000_0000;
        if_valid  = 1'b1;
        wait_grant(1'b0, 1'b1);
        chk("t1_m_addr", m_addr, 64'h8000_0000);
        chk("t1_m_wen_wmask", 64'({m_wen, m_wmask}), 64'd0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("t1_rsp_timing", 64'(if_rsp_valid), 64'(k == 3));
        end
        drain();

        // 2: LS write.
        ls_addr  = 64'h8000_1000;
        ls_wen   = 1'b1;
        ls_wdata = 64'h0000_0000_DEAD_BEEF;
        ls_wmask = 8'h0F;
        ls_valid = 1'b1;
        wait_grant(1'b1, 1'b1);
        chk("t2_m_addr", m_addr, 64'h8000_1000);
        chk("t2_m_wen", 64'(m_wen), 64'd1);
        chk("t2_m_wmask", 64'(m_wmask), 64'h0F);
        chk("t2_m_wdata", m_wdata, 64'h0000_0000_DEAD_BEEF);
        drain();

        // 3: both valid from reset, LS first then alternating, one grant every 4 cycles.
        apply_reset();
        ls_wen   = 1'b0;
        ls_wmask = '0;
        if_addr  = 64'h8000_0100;
        ls_addr  = 64'h8000_2000;
        if_valid = 1'b1;
        ls_valid = 1'b1;
        exp_ls   = 1'b1;
        grants   = 0;
        last_c   = 0;
        ri       = n_if_rsp;
        rl       = n_ls_rsp;
        for (int c = 0; c < 200 && grants < 8; c++) begin
            @(negedge clk);
            g_ls = ls_ready;
            g_if = if_ready;
            if (g_ls || g_if) begin
                chk("t3_alt_grant", 64'({g_ls, g_if}), exp_ls ? 64'd2 : 64'd1);
                if (grants > 0) chk("t3_grant_spacing", 64'(c - last_c), 64'd4);
                if (g_ls) push_exp(1'b1, ls_addr, 1'b0, slv_delay);
                else      push_exp(1'b0, if_addr, 1'b0, slv_delay);
                last_c = c;
                grants++;
                exp_ls = !exp_ls;
            end
            @(posedge clk);
            #1;
            if (g_ls) ls_addr = ls_addr + 64'd8;
            if (g_if) if_addr = if_addr + 64'd4;
            if (grants == 8) begin
                if_valid = 1'b0;
                ls_valid = 1'b0;
            end
        end
        if_valid = 1'b0;
        ls_valid = 1'b0;
        chk("t3_grant_count", 64'(grants), 64'd8);
        drain();
        chk("t3_if_rsp_count", 64'(n_if_rsp - ri), 64'd4);
        chk("t3_ls_rsp_count", 64'(n_ls_rsp - rl), 64'd4);

        // 4: timeouts. Stray response 2 cycles after the error pulse must be ignored.
        slv_delay = 6;
        if_addr   = 64'h8000_0200;
        if_valid  = 1'b1;
        wait_grant(1'b0, 1'b1);
        drain();
        chk("t4_err_hold", 64'(if_err), 64'd1);
        chk("t4_rdata_hold", if_rdata, 64'd0);
        // response in the last counted WAIT cycle beats the timeout
        slv_delay = 3;
        ls_addr   = 64'h8000_3000;
        ls_wen    = 1'b0;
        ls_valid  = 1'b1;
        wait_grant(1'b1, 1'b1);
        drain();
        // one cycle too late: error, and the late response lands in RESP
        slv_delay = 4;
        ls_addr   = 64'h8000_3008;
        ls_valid  = 1'b1;
        wait_grant(1'b1, 1'b1);
        drain();
        chk("t4_ls_err_hold", 64'(ls_err), 64'd1);
        slv_delay = 2;
        if_addr   = 64'h8000_0300;
        if_valid  = 1'b1;
        wait_grant(1'b0, 1'b1);
        drain();
        chk("t4_if_err_cleared", 64'(if_err), 64'd0);

        // 5: downstream backpressure for 10 cycles with IF also waiting.
        slv_delay   = 0;
        m_req_ready = 1'b0;
        ls_addr     = 64'h8000_4000;
        ls_valid    = 1'b1;
        wait_grant(1'b1, 1'b1);
        ls_addr  = 64'h8000_4040;
        if_addr  = 64'h8000_0400;
        if_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t5_req_valid", 64'(m_req_valid), 64'd1);
            chk("t5_m_addr", m_addr, 64'h8000_4000);
            chk("t5_ready", 64'({if_ready, ls_ready}), 64'd0);
            @(posedge clk);
            #1;
        end
        m_req_ready = 1'b1;
        wait_grant(1'b0, 1'b1);
        drain();

        // 6: asynchronous reset during WAIT; the slave's later response must be ignored.
        slv_delay = 5;
        if_addr   = 64'h8000_0500;
        if_valid  = 1'b1;
        wait_grant(1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("t6_pre_rst_addr", m_addr, 64'h8000_0500);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_m_addr", m_addr, 64'd0);
        chk("t6_rst_if_rdata", if_rdata, 64'd0);
        chk("t6_rst_ls_rdata", ls_rdata, 64'd0);
        chk("t6_rst_ctrl", 64'({m_req_valid, if_rsp_valid, ls_rsp_valid, if_err, ls_err}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("t6_no_rsp", 64'({if_rsp_valid, ls_rsp_valid}), 64'd0);
        end
        drain();
        slv_delay = 0;
        if_addr   = 64'h8000_0600;
        if_valid  = 1'b1;
        wait_grant(1'b0, 1'b1);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_22041461_mem_arbiter.md
Name: ysyx_22041461_mem_arbiter

Overview:
- Two-master, one-slave memory arbiter for the multi-cycle NPC core.
- Shares the single data-memory port between the instruction fetch unit (IF, read-only) and the load/store unit (LS, read/write).
- One transaction is outstanding at a time. Requests are registered, and responses are routed back to the requester that owns the grant.
- A response timeout reports a bus error instead of hanging the core.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width
TIMEOUT, 255, max cycles in WAIT before error response (1..65535)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
if_valid  in  1  IF read request
if_ready  out  1  IF request accepted this cycle
if_addr  in  ADDR_W  IF read address
if_rsp_valid  out  1  IF response, one-cycle pulse
if_rdata  out  DATA_W  IF read data
if_err  out  1  IF response is a timeout error
ls_valid  in  1  LS request
ls_ready  out  1  LS request accepted this cycle
ls_addr  in  ADDR_W  LS address
ls_wen  in  1  1 = write, 0 = read
ls_wdata  in  DATA_W  write data
ls_wmask  in  DATA_W/8  byte strobes
ls_rsp_valid  out  1  LS response, one-cycle pulse (read data or write ack)
ls_rdata  out  DATA_W  LS read data
ls_err  out  1  LS response is a timeout error
m_req_valid  out  1  downstream request valid
m_req_ready  in  1  downstream accepts request
m_addr  out  ADDR_W  registered address
m_wen  out  1  registered write enable
m_wdata  out  DATA_W  registered write data
m_wmask  out  DATA_W/8  registered strobes (0 for IF)
m_rsp_valid  in  1  downstream response/ack
m_rdata  in  DATA_W  downstream read data

Behaviour:

Reset:
- rst_n low forces state IDLE, owner=IF, last_grant=IF, timeout count 0.
- All outputs read 0: ready, rsp_valid and err lines; m_req_valid; data and address regs.
- Reset asserted mid-transaction abandons it. No response is issued. A downstream response arriving after reset is ignored.

FSM states: IDLE, REQ, WAIT, RESP.

IDLE:
- Only LS valid: grant LS. Only IF valid: grant IF.
- Both valid: grant the master that is not last_grant (alternating). This gives no starvation for either master.
- Grant is combinational: granted master's ready=1 in the same cycle its valid is high.
- On grant: capture addr/wen/wdata/wmask into m_* regs, set owner, update last_grant, go REQ.
- IF grants force m_wen=0 and m_wmask=0.
- ready is only ever high in IDLE.

REQ:
- m_req_valid=1, m_* held stable.
- When m_req_ready=1, go WAIT next cycle (m_req_valid drops) and clear the counter.
- No timeout is applied in REQ.

WAIT:
- Counter increments each cycle.
- m_rsp_valid=1: latch m_rdata (latch 0 when owner issued a write), err=0, go RESP.
- Counter reaches TIMEOUT with no response: rdata=0, err=1, go RESP.
- If m_rsp_valid arrives in the same cycle as the timeout, the response wins (err=0).

RESP:
- For exactly one cycle, owner's rsp_valid=1 with rdata/err. The other master's rsp_valid stays 0.
- Go IDLE. New grants are possible on the following cycle.
- Sustained back-to-back throughput: one transaction per 4 cycles minimum (IDLE→REQ→WAIT→RESP) with zero-latency slave.

Other rules:
- m_rsp_valid outside WAIT (stray or late after timeout) is ignored and does not change state.
- rdata and err hold their last value between responses. Only rsp_valid is a pulse.
- Requester inputs may change while not granted. Values are sampled only at grant.

Test Plan:
1. IF alone: if_addr=0x80000000, slave ready immediately, rsp next cycle with m_rdata=0x00000013_00100073 → if_ready high in the request cycle; if_rsp_valid pulses 3 cycles after grant with that data; if_err=0.
2. LS write: ls_addr=0x80001000, wen=1, wdata=0xDEADBEEF, wmask=0x0F → m_wen=1, m_wmask=0x0F, m_wdata=0xDEADBEEF; ls_rsp_valid pulses with rdata=0, if_rsp_valid stays 0.
3. Both valid every cycle from reset for 8 transactions → grants alternate LS, IF, LS, IF… (last_grant=IF at reset ⇒ LS first); each gets 4 responses.
4. Timeout with TIMEOUT=4: slave accepts the request but never responds → owner's rsp_valid pulses with err=1, rdata=0 after 4 WAIT cycles; an m_rsp_valid injected 2 cycles later is ignored.
5. Backpressure: m_req_ready held low 10 cycles → m_req_valid and m_addr are stable for all 10 cycles, and both ready outputs stay 0.
6. rst_n pulsed low during WAIT → outputs 0 immediately (asynchronous); no rsp_valid after release; next IF request completes normally.
